// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_pkg;

  // Arbiter phases: waiting for a request, grant offered, transfer running, one-cycle turnaround
  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBusy,
    StTurn
  } state_t;

  localparam int unsigned DEF_NUM_MASTERS = 4;
  localparam int unsigned DEF_GNT_TIMEOUT = 16;

  // PCI sideband signals are active-low
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/rr_select.sv
// Round-robin requester selection: first asserted REQ# strictly after the last owner,
// wrapping around; the last owner wins again only if it is the sole requester.
module rr_select
  import pci_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last,
  output logic [$clog2(NUM_MASTERS)-1:0] winner,
  output logic                           any_req
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  logic [IW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester after last is kept;
  // an X on a req bit fails the equality test and is treated as not requesting
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    idx     = '0;
    for (int off = int'(NUM_MASTERS); off >= 1; off--) begin
      idx = IW'((int'(last) + off) % int'(NUM_MASTERS));
      if (req[idx] == ASSERTED) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grant, frame wait timeout, preemption during a transfer,
// and a mandatory one-cycle turnaround between grants. All outputs are registered.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame,
  input  logic                           irdy,
  input  logic [NUM_MASTERS-1:0]         req,
  output logic [NUM_MASTERS-1:0]         GNT,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           bus_busy,
  output logic                           timeout
);

  localparam int unsigned OW = $clog2(NUM_MASTERS);
  localparam int unsigned CW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(GNT_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;

  logic [OW-1:0] winner;
  logic          any_req;
  logic          bus_idle, frame_low, owner_req, others_req, grant_on;

  rr_select #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_select (
    .req    (req),
    .last   (owner_q),
    .winner (winner),
    .any_req(any_req)
  );

  // Decode bus status and request bits; X inputs fail the equality tests and read as inactive
  always_comb begin
    bus_idle   = 1'b0;
    frame_low  = 1'b0;
    owner_req  = 1'b0;
    others_req = 1'b0;
    if (frame == DEASSERTED && irdy == DEASSERTED) bus_idle = 1'b1;
    if (frame == ASSERTED) frame_low = 1'b1;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (req[OW'(i)] == ASSERTED) begin
        if (OW'(i) == owner_q) owner_req = 1'b1;
        else                   others_req = 1'b1;
      end
    end
  end

  // Next-state, counter and registered-output values
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    grant_on  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (any_req && bus_idle) begin
          state_d  = StGrant;
          owner_d  = winner;
          grant_on = 1'b1;
        end
      end
      StGrant: begin
        // frame takes priority over an expiring wait count
        if (frame_low) begin
          state_d  = StBusy;
          grant_on = 1'b1;
        end else if (!owner_req) begin
          state_d = StTurn;
        end else if (cnt_q == CntLast) begin
          state_d   = StTurn;
          timeout_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          grant_on = 1'b1;
        end
      end
      StBusy: begin
        // Once GNT# drops it stays high until the transfer ends
        if (bus_idle) begin
          state_d = StTurn;
        end else if (gnt_q[owner_q] == ASSERTED && owner_req && !others_req) begin
          grant_on = 1'b1;
        end
      end
      StTurn: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    gnt_d = '1;
    if (grant_on) gnt_d[owner_d] = ASSERTED;
    busy_d = (state_d == StBusy);
  end

  // State and output registers; reset forces GNT# high without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '1;
      owner_q   <= OW'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign GNT      = gnt_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;
  assign timeout  = timeout_q;

endmodule
